pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register; successor to the fixed-width fetch/decode register.
- Carries an arbitrary packed payload (instruction, PCs, control bits) between any two pipeline stages.
- Adds a valid/ready handshake with a 2-entry skid buffer, so the upstream ready is fully registered and never combinationally dependent on downstream ready.
- Keeps synchronous flush that injects a configurable NOP payload.

Parameters:
- DATA_W, 96, payload width in bits (e.g. Instr|PC|PC+4).
- RESET_VALUE, '0, Out_Data value after RST.
- FLUSH_VALUE, {32'h00000013, 64'h0}, Out_Data value after Flush (ADDI x0,x0,0 in the upper instruction field).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- Flush  in  1  synchronous flush; discards all held entries.
- In_Valid  in  1  upstream payload valid.
- In_Data  in  DATA_W  upstream payload.
- In_Ready  out  1  block can accept; registered (equals !skid_valid).
- Out_Valid  out  1  Out_Data is valid.
- Out_Data  out  DATA_W  payload to the next stage.
- Out_Ready  in  1  downstream accepts (the inverse of stall).

Behaviour:
- Storage:
  - Main entry M drives Out_Valid/Out_Data directly.
  - Skid entry S holds one overflow payload.
- Transfer rules:
  - Accept = In_Valid & In_Ready.
  - Drain = Out_Valid & Out_Ready.
- Priority per cycle: RST > Flush > normal operation.
- RST: M_valid=0, S_valid=0, Out_Data=RESET_VALUE, In_Ready=1 on the next cycle.
- Flush: M_valid=0, S_valid=0, Out_Data=FLUSH_VALUE, In_Ready=1 next cycle. Any input accepted in the flush cycle is discarded; a drain in the flush cycle still counts as completed downstream.
- Normal operation, next state:
  - M empty or Drain, S empty: M <= In_Data if Accept, else M_valid=0 (Out_Data holds its last value).
  - M empty or Drain, S full: M <= S, S_valid=0. In_Ready was 0, so there is no Accept.
  - M full and no Drain, Accept: S <= In_Data, S_valid=1 (In_Ready drops next cycle).
  - M full and no Drain, no Accept: hold.
- Latency and throughput:
  - 1 cycle In to Out when the block is empty.
  - Sustained throughput is 1 per cycle with Out_Ready=1.
- Ordering: strictly FIFO. No entry is ever lost or duplicated.
- In_Ready timing:
  - Falls only the cycle after S fills.
  - Rises the cycle after S empties.
- Out_Data is stable while Out_Valid=1 and Out_Ready=0.
- In_Data is don't-care when In_Valid=0; it must not be captured.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- When defined:
  - Adds output Bubble_Cnt (32 bits): counts cycles with Out_Ready=1 and Out_Valid=0.
  - Adds output Stall_Cnt (32 bits): counts cycles with Out_Valid=1 and Out_Ready=0.
  - Both counters saturate at 32'hFFFFFFFF.
  - Both clear on RST only; Flush does not clear them.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - NOP_INSTR = 32'h00000013.
  - Typedefs ifid_payload_t, idex_payload_t (packed structs) so users set DATA_W = $bits(type).
  - Constant PERF_CNT_W = 32.
- One natural sub-module: sat_counter (PERF_CNT_W, enable, sync clear), instantiated twice under PIPE_STAGE_PERF_EN.

Test Plan:
- Reset: hold RST 2 cycles with In_Valid=1, In_Data=0xA5 -> Out_Valid=0, Out_Data=RESET_VALUE, In_Ready=1 after release.
- Streaming: Out_Ready=1, feed payloads 1..8 back-to-back -> Out_Data shows 1..8 one per cycle, 1-cycle latency, In_Ready stays 1.
- Backpressure: Out_Ready=0, drive 1,2,3 -> 1 in M, 2 in S, In_Ready=0 from cycle 3, 3 is held upstream. Raise Out_Ready -> output order 1,2,3 with no loss or duplicate.
- Flush with both entries full -> next cycle Out_Valid=0, Out_Data upper 32 bits = 0x00000013, In_Ready=1; the payload offered in the flush cycle never appears.
- Flush and RST in the same cycle -> Out_Data=RESET_VALUE (RST wins).
- PIPE_STAGE_PERF_EN:
  - 5 bubble cycles + 3 stall cycles -> Bubble_Cnt=5, Stall_Cnt=3.
  - Preload near max -> counter stays at 0xFFFFFFFF.
  - Flush -> counts unchanged.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the generic inter-stage pipeline register.
// Payload structs let users size the register with DATA_W = $bits(<type>).
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h00000013;
    localparam int          PERF_CNT_W = 32;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } ifid_payload_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
    } idex_payload_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int W = PERF_CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Define PIPE_STAGE_PERF_EN to add saturating bubble/stall counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W      = 96,
    parameter logic [DATA_W-1:0]  RESET_VALUE = '0,
    parameter logic [DATA_W-1:0]  FLUSH_VALUE = DATA_W'({NOP_INSTR, 64'h0})
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Flush,
    input  logic              In_Valid,
    input  logic [DATA_W-1:0] In_Data,
    output logic              In_Ready,
    output logic              Out_Valid,
    output logic [DATA_W-1:0] Out_Data,
    input  logic              Out_Ready
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] Bubble_Cnt,
    output logic [PERF_CNT_W-1:0] Stall_Cnt
`endif
);

    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q,  m_data_d;
    logic              s_valid_q, s_valid_d;
    logic [DATA_W-1:0] s_data_q,  s_data_d;
    logic              accept;
    logic              drain;

    // In_Ready comes straight from a flop, so it never depends on Out_Ready.
    assign In_Ready  = ~s_valid_q;
    assign Out_Valid = m_valid_q;
    assign Out_Data  = m_data_q;

    assign accept = In_Valid & ~s_valid_q;
    assign drain  = m_valid_q & Out_Ready;

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        if (!m_valid_q || drain) begin
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_data_d  = s_data_q;
                s_valid_d = 1'b0;
            end else if (accept) begin
                m_valid_d = 1'b1;
                m_data_d  = In_Data;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (accept) begin
            s_valid_d = 1'b1;
            s_data_d  = In_Data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            m_data_q  <= RESET_VALUE;
        end else if (Flush) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            m_data_q  <= FLUSH_VALUE;
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    // Skid payload is only meaningful while s_valid_q is set, so it needs no reset.
    always_ff @(posedge CLK) begin
        s_data_q <= s_data_d;
    end

`ifdef PIPE_STAGE_PERF_EN
    sat_counter #(.W(PERF_CNT_W)) u_bubble_cnt (
        .clk_i (CLK),
        .rst_i (RST),
        .en_i  (Out_Ready & ~m_valid_q),
        .cnt_o (Bubble_Cnt)
    );

    sat_counter #(.W(PERF_CNT_W)) u_stall_cnt (
        .clk_i (CLK),
        .rst_i (RST),
        .en_i  (m_valid_q & ~Out_Ready),
        .cnt_o (Stall_Cnt)
    );
`endif

endmodule
